ocr_result_packer: RTL and testbench

//  Upstream neighbour of the TX unit. Collects the per-plate OCR character stream and packs each plate into one
//  PIO_DATA_WIDTH result word. Pushes each word into Result_FILO and maintains the headcount the TX unit transmits from.

---
 rtl/ocr_result_packer_if.sv | 21 ++
 rtl/ocr_result_packer.sv | 140 ++++++++++++++
 tb/tb_ocr_result_packer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ocr_result_packer_if.sv
// OCR character stream in, packed FILO write out.
interface ocr_result_packer_if #(
  parameter int unsigned DATA_W = 128
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_eop;
  logic              char_ready;
  logic              push;
  logic [DATA_W-1:0] data_out;

  modport master (
    output char_valid, char_data, char_eop,
    input  char_ready, push, data_out
  );

  modport slave (
    input  char_valid, char_data, char_eop,
    output char_ready, push, data_out
  );
endinterface

// File: rtl/ocr_result_packer.sv
// Packs one plate of OCR characters into a result word, pushes it to the FILO,
// tracks the pushed headcount and signals frame completion to control.
module ocr_result_packer #(
  parameter int unsigned PIO_DATA_WIDTH = 128,
  parameter int unsigned MAX_CHARS      = 15,
  parameter int unsigned MAX_RESULTS    = 24
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      Clear_buff,
  input  logic                      frame_end,
  input  logic                      tx_busy,
  ocr_result_packer_if.slave        bus,
  output logic [7:0]                headcount,
  output logic                      frame_ready,
  output logic                      overflow
);

  localparam int unsigned CNT_W = $clog2(MAX_CHARS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;

  state_e                         state_q, state_d;
  logic [MAX_CHARS-1:0][7:0]      slots_q, slots_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           trunc_q, trunc_d;
  logic                           push_q, push_d;
  logic [PIO_DATA_WIDTH-1:0]      data_q, data_d;
  logic [7:0]                     head_q, head_d;
  logic                           fr_q, fr_d;
  logic                           ovf_q, ovf_d;
  logic                           pend_q, pend_d;
  logic                           rdy_q, rdy_d;
  logic                           accept;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      slots_q <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
      head_q  <= '0;
      fr_q    <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
      push_q  <= push_d;
      data_q  <= data_d;
      head_q  <= head_d;
      fr_q    <= fr_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    count_d = count_q;
    trunc_d = trunc_q;
    push_d  = 1'b0;
    data_d  = data_q;
    head_d  = head_q;
    fr_d    = 1'b0;
    ovf_d   = ovf_q;
    pend_d  = pend_q | frame_end;
    accept  = bus.char_valid & rdy_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (bus.char_eop) begin
            // An empty plate produces nothing and leaves the FSM in IDLE
            if (count_q != '0) state_d = EMIT;
          end else begin
            if (count_q < CNT_W'(MAX_CHARS)) begin
              slots_d[count_q] = bus.char_data;
              count_d          = count_q + CNT_W'(1);
            end else begin
              trunc_d = 1'b1;
            end
            state_d = COLLECT;
          end
        end
      end
      EMIT: begin
        if (!tx_busy) begin
          if (head_q < 8'(MAX_RESULTS)) begin
            push_d = 1'b1;
            data_d = {slots_q, trunc_q, 3'b000, 4'(count_q)};
            head_d = head_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
          slots_d = '0;
          count_d = '0;
          trunc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame completion is only reported from IDLE, after any pending plate landed
    if (state_q == IDLE && pend_d) begin
      fr_d   = (head_q != 8'd0);
      pend_d = 1'b0;
    end

    if (Clear_buff) begin
      state_d = IDLE;
      slots_d = '0;
      count_d = '0;
      trunc_d = 1'b0;
      push_d  = 1'b0;
      head_d  = '0;
      ovf_d   = 1'b0;
      pend_d  = 1'b0;
      fr_d    = 1'b0;
    end

    rdy_d = (state_d != EMIT);
  end

  assign bus.char_ready = rdy_q;
  assign bus.push       = push_q;
  assign bus.data_out   = data_q;
  assign headcount      = head_q;
  assign frame_ready    = fr_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_ocr_result_packer.sv
// Self-checking bench for ocr_result_packer: directed scenarios plus random plates
// compared against a queue-based reference of the packing rules.
module tb_ocr_result_packer;

  typedef logic [7:0] ch_q_t[$];

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       Clear_buff = 1'b0;
  logic       frame_end = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] headcount;
  logic       frame_ready;
  logic       overflow;

  ocr_result_packer_if #(.DATA_W(128)) bus();

  ocr_result_packer dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .Clear_buff  (Clear_buff),
    .frame_end   (frame_end),
    .tx_busy     (tx_busy),
    .bus         (bus),
    .headcount   (headcount),
    .frame_ready (frame_ready),
    .overflow    (overflow)
  );

  always #5 clk_in = ~clk_in;

  int           errors = 0;
  int           checks = 0;
  int           exp_hc = 0;
  logic         exp_ovf = 1'b0;
  int           fr_cnt = 0;
  logic [127:0] obs_q[$];

  always @(negedge clk_in) begin
    if (bus.push === 1'b1) obs_q.push_back(bus.data_out);
    if (frame_ready === 1'b1) fr_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic eop);
    int n = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = d;
    bus.char_eop   = eop;
    while (bus.char_ready !== 1'b1 && n < 50) begin
      cyc(1);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $error("FAIL beat_timeout observed=char_ready_low expected=accept_within_50");
    end
    cyc(1);
    bus.char_valid = 1'b0;
    bus.char_eop   = 1'b0;
  endtask

  // Reference packing: header = {trunc,000,count}, char k in byte k+1
  function automatic logic [127:0] pack(input ch_q_t s);
    logic [127:0] w = '0;
    int n = (s.size() > 15) ? 15 : s.size();
    for (int k = 0; k < n; k++) w[8*k+8 +: 8] = s[k];
    w[3:0] = 4'(n);
    w[7]   = (s.size() > 15);
    return w;
  endfunction

  function automatic ch_q_t rand_plate(input int len);
    ch_q_t s;
    for (int i = 0; i < len; i++) s.push_back(8'($urandom_range(32, 126)));
    return s;
  endfunction

  task automatic run_plate(input ch_q_t s, input string tag, output logic [127:0] w);
    obs_q.delete();
    foreach (s[i]) beat(s[i], 1'b0);
    beat(8'h00, 1'b1);
    cyc(4);
    w = (obs_q.size() > 0) ? obs_q[0] : '0;
    if (exp_hc < 24) begin
      chk({tag, "_npush"}, 128'(obs_q.size()), 128'd1);
      chk({tag, "_word"}, w, pack(s));
      exp_hc++;
    end else begin
      chk({tag, "_npush"}, 128'(obs_q.size()), 128'd0);
      exp_ovf = 1'b1;
    end
    chk({tag, "_headcount"}, 128'(headcount), 128'(exp_hc));
    chk({tag, "_overflow"}, 128'(overflow), 128'(exp_ovf));
  endtask

  initial begin
    ch_q_t        s;
    logic [127:0] w;
    int           plate_no;

    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.char_eop   = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_push", 128'(bus.push), 128'd0);
    chk("rst_data", bus.data_out, 128'd0);
    chk("rst_headcount", 128'(headcount), 128'd0);
    chk("rst_frame_ready", 128'(frame_ready), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_char_ready", 128'(bus.char_ready), 128'd0);
    reset = 1'b0;
    cyc(1);
    chk("post_rst_char_ready", 128'(bus.char_ready), 128'd1);

    // "12345678"
    s.delete();
    for (int i = 0; i < 8; i++) s.push_back(8'h31 + 8'(i));
    run_plate(s, "t1", w);
    chk("t1_hdr", 128'(w[7:0]), 128'h08);
    chk("t1_byte8", 128'(w[71:64]), 128'h38);
    chk("t1_byte9", 128'(w[79:72]), 128'h00);

    // 17 chars: truncated to 15
    s = rand_plate(17);
    run_plate(s, "t2", w);
    chk("t2_hdr", 128'(w[7:0]), 128'h8F);

    // Random plates until the FILO is full, then one more
    plate_no = 0;
    while (exp_hc < 24) begin
      s = rand_plate(int'($urandom_range(1, 20)));
      run_plate(s, $sformatf("rnd%0d", plate_no), w);
      cyc(int'($urandom_range(0, 3)));
      plate_no++;
    end
    s = rand_plate(5);
    run_plate(s, "t3_full", w);
    chk("t3_hc24", 128'(headcount), 128'd24);

    // Clear_buff in the EMIT cycle suppresses the push and clears counters
    obs_q.delete();
    s = rand_plate(4);
    foreach (s[i]) beat(s[i], 1'b0);
    beat(8'h00, 1'b1);
    Clear_buff = 1'b1;
    cyc(1);
    Clear_buff = 1'b0;
    cyc(3);
    exp_hc  = 0;
    exp_ovf = 1'b0;
    chk("clr_npush", 128'(obs_q.size()), 128'd0);
    chk("clr_headcount", 128'(headcount), 128'd0);
    chk("clr_overflow", 128'(overflow), 128'd0);

    // tx_busy holds the plate in EMIT and stalls the stream
    tx_busy = 1'b1;
    s = rand_plate(6);
    foreach (s[i]) beat(s[i], 1'b0);
    beat(8'h00, 1'b1);
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("busy_ready_%0d", i), 128'(bus.char_ready), 128'd0);
      chk($sformatf("busy_push_%0d", i), 128'(bus.push), 128'd0);
      cyc(1);
    end
    tx_busy = 1'b0;
    cyc(1);
    chk("busy_push_after", 128'(bus.push), 128'd1);
    chk("busy_word", bus.data_out, pack(s));
    cyc(1);
    chk("busy_push_one_cycle", 128'(bus.push), 128'd0);
    exp_hc++;
    chk("busy_headcount", 128'(headcount), 128'(exp_hc));

    // frame_end during COLLECT is serviced after the plate lands
    s = rand_plate(3);
    foreach (s[i]) beat(s[i], 1'b0);
    fr_cnt = 0;
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    cyc(2);
    chk("fe_no_early_pulse", 128'(fr_cnt), 128'd0);
    beat(8'h00, 1'b1);
    cyc(5);
    exp_hc++;
    chk("fe_one_pulse", 128'(fr_cnt), 128'd1);
    chk("fe_headcount", 128'(headcount), 128'(exp_hc));

    // frame_end in IDLE with headcount > 0, then with headcount = 0
    fr_cnt = 0;
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    cyc(3);
    chk("fe_idle_pulse", 128'(fr_cnt), 128'd1);
    Clear_buff = 1'b1;
    cyc(1);
    Clear_buff = 1'b0;
    exp_hc = 0;
    fr_cnt = 0;
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    cyc(3);
    chk("fe_empty_no_pulse", 128'(fr_cnt), 128'd0);

    // EOP-only beat in IDLE
    obs_q.delete();
    beat(8'h00, 1'b1);
    cyc(3);
    chk("eop_only_npush", 128'(obs_q.size()), 128'd0);
    chk("eop_only_ready", 128'(bus.char_ready), 128'd1);
    chk("eop_only_headcount", 128'(headcount), 128'(exp_hc));

    // Reset mid-plate discards the partial plate
    s = rand_plate(3);
    foreach (s[i]) beat(s[i], 1'b0);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    exp_hc  = 0;
    exp_ovf = 1'b0;
    cyc(1);
    obs_q.delete();
    beat(8'h00, 1'b1);
    cyc(3);
    chk("midrst_npush", 128'(obs_q.size()), 128'd0);
    s = rand_plate(2);
    run_plate(s, "midrst_plate", w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
